// File: rtl/uart_tx_buffered_pkg.sv
// Shared UART definitions: serializer state encoding, frame constants and baud divider math.
// The receive side imports the same package so both ends agree on the bit period.
package uart_tx_buffered_pkg;

  typedef logic [1:0] tx_state_t;

  localparam tx_state_t ST_IDLE  = 2'd0;
  localparam tx_state_t ST_START = 2'd1;
  localparam tx_state_t ST_DATA  = 2'd2;
  localparam tx_state_t ST_STOP  = 2'd3;

  localparam int DATA_BITS = 8;

  // Cycles per bit, truncated toward zero.
  function automatic int bit_div(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_tx_buffered_sync_fifo.sv
// Synchronous FIFO with a combinational head read; the caller never pushes when full
// and never pops when empty.
module sync_fifo #(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int W     = 8
) (
  input  logic          Clk,
  input  logic          Rst,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata,
  output logic [AW:0]   count
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  assign rdata = mem[rd_ptr];

  // Storage carries no reset; only pointers and occupancy define validity.
  always_ff @(posedge Clk) begin
    if (push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + {{(AW-1){1'b0}}, 1'b1};
      end
      if (pop) begin
        rd_ptr <= rd_ptr + {{(AW-1){1'b0}}, 1'b1};
      end
      case ({push, pop})
        2'b10:   count <= count + {{AW{1'b0}}, 1'b1};
        2'b01:   count <= count - {{AW{1'b0}}, 1'b1};
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter: bytes queue in a FIFO and are shifted out LSB first,
// back-to-back, with no idle gap while the queue is non-empty.
module uart_tx_buffered
  import uart_tx_buffered_pkg::*;
#(
  parameter int CLK_HZ = 50_000_000,
  parameter int BAUD   = 115200,
  parameter int DEPTH  = 16,
  parameter int AW     = 4
) (
  input  logic          Clk,
  input  logic          Rst,
  input  logic          i_fWr,
  input  logic [7:0]    i_Data,
  output logic          o_fFull,
  output logic          o_fEmpty,
  output logic [AW:0]   o_Count,
  output logic          o_fOvf,
  output logic          o_fBusy,
  output logic          o_fDone,
  output logic          o_Tx
);

  localparam int BIT_DIV = bit_div(CLK_HZ, BAUD);
  localparam int CW      = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(BIT_DIV - 1);
  localparam logic [AW:0]   DEPTH_CNT = (AW+1)'(DEPTH);
  localparam logic [2:0]    LAST_BIT  = 3'(DATA_BITS - 1);

  tx_state_t     state;
  logic [CW-1:0] baud_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic          tx_q;
  logic          ovf_q;
  logic          bit_end;
  logic          push;
  logic          pop;
  logic [7:0]    head;
  logic [AW:0]   fifo_count;

  assign o_Count  = fifo_count;
  assign o_fFull  = (fifo_count == DEPTH_CNT);
  assign o_fEmpty = (fifo_count == '0);
  assign o_fBusy  = (state != ST_IDLE);
  assign o_fDone  = (state == ST_STOP) && bit_end;
  assign o_fOvf   = ovf_q;
  assign o_Tx     = tx_q;

  assign bit_end = (baud_cnt == BAUD_LAST);
  // A full FIFO rejects a write even if the head leaves in the same cycle.
  assign push    = i_fWr && !o_fFull;
  assign pop     = !o_fEmpty && ((state == ST_IDLE) || ((state == ST_STOP) && bit_end));

  sync_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .W     (8)
  ) u_fifo (
    .Clk   (Clk),
    .Rst   (Rst),
    .push  (push),
    .pop   (pop),
    .wdata (i_Data),
    .rdata (head),
    .count (fifo_count)
  );

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state    <= ST_IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      tx_q     <= 1'b1;
      ovf_q    <= 1'b0;
    end else begin
      ovf_q <= i_fWr && o_fFull;
      case (state)
        ST_IDLE: begin
          baud_cnt <= '0;
          tx_q     <= 1'b1;
          if (pop) begin
            shift <= head;
            tx_q  <= 1'b0;
            state <= ST_START;
          end
        end
        ST_START: begin
          if (bit_end) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            tx_q     <= shift[0];
            state    <= ST_DATA;
          end else begin
            baud_cnt <= baud_cnt + CW'(1);
          end
        end
        ST_DATA: begin
          if (bit_end) begin
            baud_cnt <= '0;
            if (bit_idx == LAST_BIT) begin
              tx_q  <= 1'b1;
              state <= ST_STOP;
            end else begin
              shift   <= {1'b0, shift[7:1]};
              tx_q    <= shift[1];
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            baud_cnt <= baud_cnt + CW'(1);
          end
        end
        ST_STOP: begin
          if (bit_end) begin
            baud_cnt <= '0;
            // Chain straight into the next start bit when more bytes are waiting.
            if (pop) begin
              shift <= head;
              tx_q  <= 1'b0;
              state <= ST_START;
            end else begin
              state <= ST_IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt + CW'(1);
          end
        end
        default: begin
          state <= ST_IDLE;
          tx_q  <= 1'b1;
        end
      endcase
    end
  end

endmodule
